// File: rtl/subleq_seq.sv
// subleq_seq: multi-cycle 8-bit SUBLEQ sequencer with a req/ack memory port and bimux lane control.
// Optional build macro SUBLEQ_HALT_EN: a taken branch to 0xFF parks the core in HALT until reset.
`default_nettype none
`timescale 1ns/1ps

module subleq_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack,
  output logic       mux_dir,
  output logic [2:0] mux_sel,
  output logic [7:0] pc,
  output logic       busy,
  output logic       halt
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_FA   = 4'd1,
    S_FB   = 4'd2,
    S_FC   = 4'd3,
    S_RDA  = 4'd4,
    S_RDB  = 4'd5,
    S_WRB  = 4'd6,
    S_NEXT = 4'd7,
    S_HALT = 4'd8
  } state_t;

  state_t     state, state_nx;
  logic       gap;
  logic [7:0] a, b, c, da, db;
  logic [7:0] res;
  logic       xfer, accept, taken, halt_hit;

  assign res   = db - da;
  assign taken = res[7] | (res == 8'd0);

`ifdef SUBLEQ_HALT_EN
  assign halt_hit = taken & (c == 8'hFF);
  assign halt     = (state == S_HALT);
`else
  assign halt_hit = 1'b0;
  assign halt     = 1'b0;
`endif

  // Address and lane decode; every operand is registered, so both stay put for the whole transfer.
  always_comb begin
    xfer     = 1'b0;
    mem_addr = 8'd0;
    mux_sel  = 3'd0;
    case (state)
      S_FA:  begin xfer = 1'b1; mem_addr = pc;         mux_sel = 3'd0; end
      S_FB:  begin xfer = 1'b1; mem_addr = pc + 8'd1;  mux_sel = 3'd1; end
      S_FC:  begin xfer = 1'b1; mem_addr = pc + 8'd2;  mux_sel = 3'd2; end
      S_RDA: begin xfer = 1'b1; mem_addr = a;          mux_sel = 3'd3; end
      S_RDB: begin xfer = 1'b1; mem_addr = b;          mux_sel = 3'd4; end
      S_WRB: begin xfer = 1'b1; mem_addr = b;          mux_sel = 3'd5; end
      default: ;
    endcase
  end

  // gap suppresses the request for one cycle after every acknowledged transfer.
  assign mem_req   = xfer & ~gap;
  assign accept    = mem_req & mem_ack;
  assign mem_we    = (state == S_WRB);
  assign mux_dir   = (state == S_WRB);
  assign mem_wdata = (state == S_WRB) ? res : 8'd0;
  assign busy      = (state != S_IDLE) && (state != S_HALT);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start)  state_nx = S_FA;
      S_FA:   if (accept) state_nx = S_FB;
      S_FB:   if (accept) state_nx = S_FC;
      S_FC:   if (accept) state_nx = S_RDA;
      S_RDA:  if (accept) state_nx = S_RDB;
      S_RDB:  if (accept) state_nx = S_WRB;
      S_WRB:  if (accept) state_nx = S_NEXT;
      S_NEXT: state_nx = halt_hit ? S_HALT : S_FA;
      S_HALT: state_nx = S_HALT;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      gap   <= 1'b0;
      pc    <= 8'd0;
      a     <= 8'd0;
      b     <= 8'd0;
      c     <= 8'd0;
      da    <= 8'd0;
      db    <= 8'd0;
    end else begin
      state <= state_nx;
      gap   <= accept;
      if (accept) begin
        case (state)
          S_FA:  a  <= mem_rdata;
          S_FB:  b  <= mem_rdata;
          S_FC:  c  <= mem_rdata;
          S_RDA: da <= mem_rdata;
          S_RDB: db <= mem_rdata;
          default: ;
        endcase
      end
      if (state == S_NEXT) pc <= taken ? c : pc + 8'd3;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_subleq_seq.sv
// tb_subleq_seq: scoreboard bench for subleq_seq; a reference interpreter predicts every memory transfer.
// Build with +define+SUBLEQ_HALT_EN to exercise the halting variant.
`default_nettype none
`timescale 1ns/1ps

module tb_subleq_seq;

  logic       clk, rst_n, start;
  logic       mem_req, mem_we, mem_ack, mux_dir, busy, halt;
  logic [7:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic [2:0] mux_sel;

  subleq_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mux_dir(mux_dir), .mux_sel(mux_sel),
    .pc(pc), .busy(busy), .halt(halt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
    logic [2:0] sel;
  } xfer_t;

  xfer_t      exp_q[$];
  logic [7:0] mem [0:255];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         max_delay = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic push(input logic we, input logic [7:0] addr, input logic [7:0] data, input logic [2:0] sel);
    xfer_t e;
    e.we = we; e.addr = addr; e.data = data; e.sel = sel;
    exp_q.push_back(e);
  endtask

  // Reference interpreter: runs n instructions on a copy of mem, queueing the transfers they imply.
  task automatic build_model(input int n, output logic [7:0] end_pc, output bit halted);
    logic [7:0] m [0:255];
    logic [7:0] p, p1, p2, a, b, c, res;
    bit tk;
    m = mem;
    p = 8'd0;
    halted = 1'b0;
    for (int i = 0; i < n && !halted; i++) begin
      p1 = p + 8'd1;
      p2 = p + 8'd2;
      a = m[p]; b = m[p1]; c = m[p2];
      push(1'b0, p,  8'd0, 3'd0);
      push(1'b0, p1, 8'd0, 3'd1);
      push(1'b0, p2, 8'd0, 3'd2);
      push(1'b0, a,  8'd0, 3'd3);
      push(1'b0, b,  8'd0, 3'd4);
      res = m[b] - m[a];
      push(1'b1, b, res, 3'd5);
      m[b] = res;
      tk = res[7] || (res == 8'd0);
`ifdef SUBLEQ_HALT_EN
      if (tk && c == 8'hFF) halted = 1'b1;
`endif
      p = tk ? c : p + 8'd3;
    end
    end_pc = p;
  endtask

  // Memory responder: random ack latency, spurious acks while idle, hold and gap checks.
  initial begin : responder
    bit         waiting, acked_last, s_we;
    int         cnt;
    logic [7:0] s_addr, s_wdata;
    xfer_t      e;
    waiting = 0; acked_last = 0; cnt = 0; s_we = 0; s_addr = 0; s_wdata = 0;
    mem_ack = 1'b0; mem_rdata = 8'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_ack = 1'b0; waiting = 0; acked_last = 0;
      end else if (acked_last) begin
        check("req_gap", mem_req, 1'b0);
        acked_last = 0;
        mem_ack   = ($urandom_range(2, 0) == 0);
        mem_rdata = 8'($urandom);
      end else if (mem_req) begin
        mem_ack = 1'b0;
        if (!waiting) begin
          waiting = 1; cnt = $urandom_range(max_delay, 0);
          s_addr = mem_addr; s_we = mem_we; s_wdata = mem_wdata;
        end else begin
          check("hold_addr",  mem_addr,  s_addr);
          check("hold_we",    mem_we,    s_we);
          check("hold_wdata", mem_wdata, s_wdata);
        end
        if (cnt > 0) cnt--;
        else if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("xfer_addr", mem_addr, e.addr);
          check("xfer_we",   mem_we,   e.we);
          check("mux_sel",   mux_sel,  e.sel);
          check("mux_dir",   mux_dir,  e.we);
          if (e.we) check("wdata", mem_wdata, e.data);
          if (e.sel == 3'd0) check("fetch_pc", pc, e.addr);
          if (mem_we) mem[mem_addr] = mem_wdata;
          else        mem_rdata = mem[mem_addr];
          mem_ack = 1'b1; acked_last = 1; waiting = 0;
        end
      end else begin
        mem_ack   = ($urandom_range(2, 0) == 0);
        mem_rdata = 8'($urandom);
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Done when every predicted transfer is consumed and the next fetch waits unacked, or the core halted.
  task automatic wait_done();
    bit ok = 0;
    for (int cyc = 0; cyc < 3000 && !ok; cyc++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && ((mem_req && !mem_ack) || halt)) ok = 1;
    end
    check("done_in_time", ok, 1'b1);
  endtask

  task automatic run_prog(input int n, input int mdly, input bit restart_mid,
                          output logic [7:0] epc, output bit eh);
    build_model(n, epc, eh);
    max_delay = mdly;
    pulse_start();
    if (restart_mid) begin
      repeat (7) @(negedge clk);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    wait_done();
    check("end_pc", pc, epc);
    if (!eh) check("next_fetch_addr", mem_addr, epc);
  endtask

  task automatic load_wrap_prog();
    clear_mem();
    mem[8'h00] = 8'h10; mem[8'h01] = 8'h11; mem[8'h02] = 8'hFE;
    mem[8'h10] = 8'h01; mem[8'h11] = 8'h01;
    mem[8'hFE] = 8'h20; mem[8'hFF] = 8'h21;
    mem[8'h20] = 8'h02; mem[8'h21] = 8'h09;
  endtask

  initial begin : main
    logic [7:0] epc;
    bit eh, found;
    clk = 1'b0; rst_n = 1'b0; start = 1'b0;
    #1;
    check("rst_req",   mem_req,   1'b0);
    check("rst_we",    mem_we,    1'b0);
    check("rst_dir",   mux_dir,   1'b0);
    check("rst_sel",   mux_sel,   3'd0);
    check("rst_addr",  mem_addr,  8'd0);
    check("rst_wdata", mem_wdata, 8'd0);
    check("rst_busy",  busy,      1'b0);
    check("rst_halt",  halt,      1'b0);
    check("rst_pc",    pc,        8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Not-taken: 5-2=3 written to 0x11, pc advances to 3.
    clear_mem();
    mem[8'h00] = 8'h10; mem[8'h01] = 8'h11; mem[8'h02] = 8'h03;
    mem[8'h10] = 8'h02; mem[8'h11] = 8'h05;
    run_prog(1, 0, 1'b0, epc, eh);
    check("s1_pc", pc, 8'h03);
    check("s1_mem", mem[8'h11], 8'h03);
    check("s1_busy", busy, 1'b1);

    // Taken on zero: 2-2=0, branch to C=3.
    do_reset();
    clear_mem();
    mem[8'h00] = 8'h10; mem[8'h01] = 8'h11; mem[8'h02] = 8'h03;
    mem[8'h10] = 8'h02; mem[8'h11] = 8'h02;
    run_prog(1, 0, 1'b0, epc, eh);
    check("s2_pc", pc, 8'h03);
    check("s2_mem", mem[8'h11], 8'h00);

    // Branch to 0xFE, then operand fetch wraps to 0x00 and pc wraps to 0x01.
    do_reset();
    load_wrap_prog();
    run_prog(2, 2, 1'b0, epc, eh);
    check("wrap_pc", pc, 8'h01);
    check("wrap_mem", mem[8'h21], 8'h07);

    // Random memory image, slow acks, and a stray start mid-run.
    do_reset();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    run_prog(10, 5, 1'b1, epc, eh);

    // Taken branch to 0xFF with A=B: writes 0.
    do_reset();
    clear_mem();
    mem[8'h00] = 8'h10; mem[8'h01] = 8'h11; mem[8'h02] = 8'hFF;
    mem[8'h10] = 8'h07; mem[8'h11] = 8'h07;
    run_prog(1, 0, 1'b0, epc, eh);
    check("ff_pc", pc, 8'hFF);
    check("ff_mem", mem[8'h11], 8'h00);
`ifdef SUBLEQ_HALT_EN
    check("halt_flag", halt, 1'b1);
    check("halt_busy", busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("halt_no_req", mem_req, 1'b0);
    end
    pulse_start();
    repeat (3) @(negedge clk);
    #1;
    check("halt_after_start", halt, 1'b1);
    check("halt_req_after_start", mem_req, 1'b0);
`else
    check("nohalt_flag", halt, 1'b0);
    check("nohalt_busy", busy, 1'b1);
`endif

    // Asynchronous reset while the B operand read is outstanding.
    do_reset();
    load_wrap_prog();
    build_model(2, epc, eh);
    max_delay = 5;
    pulse_start();
    found = 0;
    for (int cyc = 0; cyc < 2000 && !found; cyc++) begin
      @(negedge clk); #1;
      if (mem_req && mux_sel == 3'd4 && pc == 8'hFE) found = 1;
    end
    check("rdb_reached", found, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_req",  mem_req,  1'b0);
    check("mid_rst_busy", busy,     1'b0);
    check("mid_rst_pc",   pc,       8'd0);
    check("mid_rst_sel",  mux_sel,  3'd0);
    check("mid_rst_addr", mem_addr, 8'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
